// File: rtl/recovery_ctrl.sv
// recovery_ctrl: runs the mispredict recovery sequence squash -> drain -> map-table restore -> fetch redirect.
// Latency: squash 1 cycle after the request; RESTORE takes 32/ROWS cycles; redirect follows the last chunk.
// Backpressure: drain waits on sq_empty/fu_busy; redirect holds until redirect_ready. RECOVERY_STATS_EN adds stat counters.
module recovery_ctrl #(
    parameter int ROB_W = 5,
    parameter int PR_W  = 6,
    parameter int XLEN  = 32,
    parameter int ROWS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 recover_req,
    input  logic [XLEN-1:0]      recover_pc,
    input  logic [ROB_W-1:0]     recover_head,
    input  logic [32*PR_W-1:0]   archi_maptable,
    input  logic                 sq_empty,
    input  logic                 fu_busy,
    input  logic                 redirect_ready,
    output logic                 squash,
    output logic                 stall_dispatch,
    output logic                 fl_recover_en,
    output logic [ROB_W-1:0]     fl_head_out,
    output logic                 mpt_wr_en,
    output logic [4:0]           mpt_wr_idx,
    output logic [ROWS*PR_W-1:0] mpt_wr_data,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 busy
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0]          recover_count,
    output logic [31:0]          recover_cycles
`endif
);

    localparam logic [4:0] LAST_IDX = 5'(32 - ROWS);
    localparam logic [4:0] STEP     = 5'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUASH,
        S_DRAIN,
        S_RESTORE,
        S_REDIRECT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q;
    logic [ROB_W-1:0]  head_q;
    logic [PR_W-1:0]   snap_q [32];
    logic [4:0]        idx_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            head_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < 32; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            // Latch only from IDLE so a late request cannot disturb a recovery in flight.
            if (state_q == S_IDLE && recover_req) begin
                pc_q   <= recover_pc;
                head_q <= recover_head;
            end
            if (state_q == S_SQUASH) begin
                for (int i = 0; i < 32; i++) snap_q[i] <= archi_maptable[i*PR_W +: PR_W];
            end
            if (state_q == S_RESTORE) idx_q <= idx_q + STEP;
            else                      idx_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (recover_req)            state_d = S_SQUASH;
            S_SQUASH:                               state_d = S_DRAIN;
            S_DRAIN:    if (sq_empty && !fu_busy)   state_d = S_RESTORE;
            S_RESTORE:  if (idx_q == LAST_IDX)      state_d = S_REDIRECT;
            S_REDIRECT: if (redirect_ready)         state_d = S_IDLE;
            default:                                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        squash         = 1'b0;
        fl_recover_en  = 1'b0;
        fl_head_out    = '0;
        mpt_wr_en      = 1'b0;
        mpt_wr_idx     = '0;
        mpt_wr_data    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state_q != S_IDLE);
        stall_dispatch = (state_q != S_IDLE);
        case (state_q)
            S_SQUASH: begin
                squash        = 1'b1;
                fl_recover_en = 1'b1;
                fl_head_out   = head_q;
            end
            S_RESTORE: begin
                mpt_wr_en  = 1'b1;
                mpt_wr_idx = idx_q;
                for (int j = 0; j < ROWS; j++) begin
                    mpt_wr_data[j*PR_W +: PR_W] = snap_q[idx_q + 5'(j)];
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
            end
            default: ;
        endcase
    end

`ifdef RECOVERY_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            recover_count  <= '0;
            recover_cycles <= '0;
        end else begin
            if (state_q == S_REDIRECT && redirect_ready && recover_count != '1)
                recover_count <= recover_count + 32'd1;
            if (state_q != S_IDLE && recover_cycles != '1)
                recover_cycles <= recover_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// Bench for recovery_ctrl: directed vector table, hand sequences for drain stall and mid-recovery reset,
// and a randomized trace checked against a scan-based reference model of the recovery timeline.
module tb_recovery_ctrl;
    localparam int ROB_W = 5;
    localparam int PR_W  = 6;
    localparam int XLEN  = 32;
    localparam int ROWS  = 8;
    localparam int NCH   = 32 / ROWS;
    localparam int L     = 600;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 recover_req;
    logic [XLEN-1:0]      recover_pc;
    logic [ROB_W-1:0]     recover_head;
    logic [32*PR_W-1:0]   archi_maptable;
    logic                 sq_empty, fu_busy, redirect_ready;
    logic                 squash, stall_dispatch, fl_recover_en;
    logic [ROB_W-1:0]     fl_head_out;
    logic                 mpt_wr_en;
    logic [4:0]           mpt_wr_idx;
    logic [ROWS*PR_W-1:0] mpt_wr_data;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 busy;
`ifdef RECOVERY_STATS_EN
    logic [31:0]          recover_count, recover_cycles;
`endif

    always #5 clock = ~clock;

    recovery_ctrl #(.ROB_W(ROB_W), .PR_W(PR_W), .XLEN(XLEN), .ROWS(ROWS)) dut (
        .clock(clock), .reset(reset), .recover_req(recover_req), .recover_pc(recover_pc),
        .recover_head(recover_head), .archi_maptable(archi_maptable), .sq_empty(sq_empty),
        .fu_busy(fu_busy), .redirect_ready(redirect_ready), .squash(squash),
        .stall_dispatch(stall_dispatch), .fl_recover_en(fl_recover_en), .fl_head_out(fl_head_out),
        .mpt_wr_en(mpt_wr_en), .mpt_wr_idx(mpt_wr_idx), .mpt_wr_data(mpt_wr_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
`ifdef RECOVERY_STATS_EN
        , .recover_count(recover_count), .recover_cycles(recover_cycles)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic             req;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] head;
        logic             sqe, fub, rdy;
        logic             sq, fl;
        logic [ROB_W-1:0] hd;
        logic             we;
        logic [4:0]       idx;
        logic             rv;
        logic [XLEN-1:0]  rpc;
        logic             bsy;
    } vec_t;

    function automatic vec_t mk(input int rq, input int p, input int h, input int se, input int fb,
                                input int rd, input int esq, input int efl, input int ehd, input int ewe,
                                input int eidx, input int erv, input int erpc, input int ebsy);
        vec_t v;
        v.req = (rq != 0);  v.pc = XLEN'(p);  v.head = ROB_W'(h);
        v.sqe = (se != 0);  v.fub = (fb != 0); v.rdy = (rd != 0);
        v.sq = (esq != 0);  v.fl = (efl != 0); v.hd = ROB_W'(ehd); v.we = (ewe != 0);
        v.idx = 5'(eidx);   v.rv = (erv != 0); v.rpc = XLEN'(erpc); v.bsy = (ebsy != 0);
        return v;
    endfunction

    // Map table entry i holds PR i, so a chunk at idx holds idx..idx+ROWS-1 (mod 32).
    function automatic logic [63:0] ident_chunk(input logic [4:0] idx);
        logic [63:0] v = '0;
        for (int j = 0; j < ROWS; j++) v[j*PR_W +: PR_W] = PR_W'((int'(idx) + j) % 32);
        return v;
    endfunction

    function automatic logic [63:0] snap_chunk(input logic [32*PR_W-1:0] snap, input int k);
        logic [63:0] v = '0;
        for (int j = 0; j < ROWS; j++) v[j*PR_W +: PR_W] = snap[((k*ROWS + j) % 32)*PR_W +: PR_W];
        return v;
    endfunction

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rq, input logic [XLEN-1:0] p, input logic [ROB_W-1:0] h,
                         input logic se, input logic fb, input logic rd);
        recover_req = rq; recover_pc = p; recover_head = h;
        sq_empty = se; fu_busy = fb; redirect_ready = rd;
    endtask

    task automatic check_out(input string tag, input logic esq, input logic efl, input logic [ROB_W-1:0] ehd,
                             input logic ewe, input logic [4:0] eidx, input logic [63:0] edat,
                             input logic erv, input logic [XLEN-1:0] erpc, input logic ebsy);
        chk({tag, ".squash"}, 64'(squash), 64'(esq));
        chk({tag, ".fl_en"}, 64'(fl_recover_en), 64'(efl));
        if (efl) chk({tag, ".fl_head"}, 64'(fl_head_out), 64'(ehd));
        chk({tag, ".wr_en"}, 64'(mpt_wr_en), 64'(ewe));
        if (ewe) begin
            chk({tag, ".wr_idx"}, 64'(mpt_wr_idx), 64'(eidx));
            chk({tag, ".wr_data"}, 64'(mpt_wr_data), edat);
        end
        chk({tag, ".rd_valid"}, 64'(redirect_valid), 64'(erv));
        if (erv) chk({tag, ".rd_pc"}, 64'(redirect_pc), 64'(erpc));
        chk({tag, ".busy"}, 64'(busy), 64'(ebsy));
        chk({tag, ".stall"}, 64'(stall_dispatch), 64'(ebsy));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".z_squash"}, 64'(squash), 64'd0);
        chk({tag, ".z_fl_en"}, 64'(fl_recover_en), 64'd0);
        chk({tag, ".z_fl_head"}, 64'(fl_head_out), 64'd0);
        chk({tag, ".z_wr_en"}, 64'(mpt_wr_en), 64'd0);
        chk({tag, ".z_wr_idx"}, 64'(mpt_wr_idx), 64'd0);
        chk({tag, ".z_wr_data"}, 64'(mpt_wr_data), 64'd0);
        chk({tag, ".z_rd_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, ".z_rd_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, ".z_busy"}, 64'(busy), 64'd0);
        chk({tag, ".z_stall"}, 64'(stall_dispatch), 64'd0);
`ifdef RECOVERY_STATS_EN
        chk({tag, ".z_count"}, 64'(recover_count), 64'd0);
        chk({tag, ".z_cycles"}, 64'(recover_cycles), 64'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        next_cyc();
        next_cyc();
        @(negedge clock);
        check_zero("reset");
        next_cyc();
        reset = 1'b1;
    endtask

    vec_t tbl [21];
    logic [32*PR_W-1:0] ident_map;

    task automatic apply_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            drive(tbl[r].req, tbl[r].pc, tbl[r].head, tbl[r].sqe, tbl[r].fub, tbl[r].rdy);
            archi_maptable = ident_map;
            @(negedge clock);
            check_out($sformatf("tbl%0d", r), tbl[r].sq, tbl[r].fl, tbl[r].hd, tbl[r].we, tbl[r].idx,
                      ident_chunk(tbl[r].idx), tbl[r].rv, tbl[r].rpc, tbl[r].bsy);
            next_cyc();
        end
    endtask

    task automatic drain_stall(input logic use_fu);
        do_reset();
        drive(1'b1, 32'd500, 5'd4, 1'b1, 1'b0, 1'b1);
        next_cyc();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, '0, '0, use_fu, use_fu, 1'b1);
            @(negedge clock);
            if (k == 1) chk("drain.squash", 64'(squash), 64'd1);
            else        chk($sformatf("drain.hold%0d", k), 64'(mpt_wr_en), 64'd0);
            chk($sformatf("drain.busy%0d", k), 64'(busy), 64'd1);
            next_cyc();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        chk("drain.release", 64'(mpt_wr_en), 64'd0);
        next_cyc();
        @(negedge clock);
        chk("drain.first_wr", 64'(mpt_wr_en), 64'd1);
        chk("drain.first_idx", 64'(mpt_wr_idx), 64'd0);
        for (int k = 0; k < NCH; k++) next_cyc();
        @(negedge clock);
        chk("drain.rd_valid", 64'(redirect_valid), 64'd1);
        chk("drain.rd_pc", 64'(redirect_pc), 64'd500);
        next_cyc();
        @(negedge clock);
        chk("drain.idle", 64'(busy), 64'd0);
        next_cyc();
    endtask

    // Random trace and its expected outputs, derived by scanning the input trace.
    logic               r_req [L];
    logic [XLEN-1:0]    r_pc [L];
    logic [ROB_W-1:0]   r_head [L];
    logic               r_sqe [L], r_fub [L], r_rdy [L];
    logic [32*PR_W-1:0] r_map [L];
    logic               e_sq [L], e_we [L], e_rv [L], e_busy [L];
    logic [ROB_W-1:0]   e_hd [L];
    logic [4:0]         e_idx [L];
    logic [63:0]        e_dat [L];
    logic [XLEN-1:0]    e_rpc [L];
    int                 n_hs, n_busy;

    task automatic build_model();
        int i, r, d, s, e, t;
        for (int k = 0; k < L; k++) begin
            e_sq[k] = 0; e_we[k] = 0; e_rv[k] = 0; e_busy[k] = 0;
            e_hd[k] = '0; e_idx[k] = '0; e_dat[k] = '0; e_rpc[k] = '0;
        end
        n_hs = 0;
        i = 0;
        while (i < L - 1) begin
            if (!r_req[i]) begin
                i++;
                continue;
            end
            r = i;
            e_sq[r+1] = 1; e_hd[r+1] = r_head[r]; e_busy[r+1] = 1;
            d = r + 2;
            while (d < L && !(r_sqe[d] && !r_fub[d])) begin
                e_busy[d] = 1;
                d++;
            end
            if (d < L) e_busy[d] = 1;
            for (int k = 0; k < NCH; k++) begin
                t = d + 1 + k;
                if (t < L) begin
                    e_we[t] = 1; e_idx[t] = 5'(k * ROWS);
                    e_dat[t] = snap_chunk(r_map[r+1], k); e_busy[t] = 1;
                end
            end
            s = d + 1 + NCH;
            e = s;
            while (e < L && !r_rdy[e]) begin
                e_rv[e] = 1; e_rpc[e] = r_pc[r]; e_busy[e] = 1;
                e++;
            end
            if (e < L) begin
                e_rv[e] = 1; e_rpc[e] = r_pc[r]; e_busy[e] = 1;
                n_hs++;
            end
            i = e + 1;
        end
        n_busy = 0;
        for (int k = 0; k < L; k++) if (e_busy[k]) n_busy++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ident_map[i*PR_W +: PR_W] = PR_W'(i);
        archi_maptable = ident_map;

        // Basic sequence with an ignored request during RESTORE, then redirect backpressure.
        tbl[0]  = mk(1, 365, 10, 1, 0, 1,  0, 0, 0,  0, 0,  0, 0,   0);
        tbl[1]  = mk(0, 0,   0,  1, 0, 1,  1, 1, 10, 0, 0,  0, 0,   1);
        tbl[2]  = mk(0, 0,   0,  1, 0, 1,  0, 0, 0,  0, 0,  0, 0,   1);
        tbl[3]  = mk(1, 999, 3,  1, 0, 1,  0, 0, 0,  1, 0,  0, 0,   1);
        tbl[4]  = mk(1, 999, 3,  1, 0, 1,  0, 0, 0,  1, 8,  0, 0,   1);
        tbl[5]  = mk(1, 999, 3,  1, 0, 1,  0, 0, 0,  1, 16, 0, 0,   1);
        tbl[6]  = mk(1, 999, 3,  1, 0, 1,  0, 0, 0,  1, 24, 0, 0,   1);
        tbl[7]  = mk(0, 0,   0,  1, 0, 1,  0, 0, 0,  0, 0,  1, 365, 1);
        tbl[8]  = mk(0, 0,   0,  1, 0, 1,  0, 0, 0,  0, 0,  0, 0,   0);
        tbl[9]  = mk(1, 738, 7,  1, 0, 0,  0, 0, 0,  0, 0,  0, 0,   0);
        tbl[10] = mk(0, 0,   0,  1, 0, 0,  1, 1, 7,  0, 0,  0, 0,   1);
        tbl[11] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  0, 0,  0, 0,   1);
        tbl[12] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  1, 0,  0, 0,   1);
        tbl[13] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  1, 8,  0, 0,   1);
        tbl[14] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  1, 16, 0, 0,   1);
        tbl[15] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  1, 24, 0, 0,   1);
        tbl[16] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  0, 0,  1, 738, 1);
        tbl[17] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  0, 0,  1, 738, 1);
        tbl[18] = mk(0, 0,   0,  1, 0, 0,  0, 0, 0,  0, 0,  1, 738, 1);
        tbl[19] = mk(0, 0,   0,  1, 0, 1,  0, 0, 0,  0, 0,  1, 738, 1);
        tbl[20] = mk(0, 0,   0,  1, 0, 1,  0, 0, 0,  0, 0,  0, 0,   0);

        do_reset();
        apply_rows(0, 20);

        drain_stall(1'b0);
        drain_stall(1'b1);

        // Reset asserted during the second RESTORE cycle.
        do_reset();
        drive(1'b1, 32'd111, 5'd5, 1'b1, 1'b0, 1'b1);
        next_cyc();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        next_cyc();
        next_cyc();
        next_cyc();
        @(negedge clock);
        chk("rst_mid.in_restore", 64'(mpt_wr_idx), 64'd8);
        reset = 1'b0;
        next_cyc();
        @(negedge clock);
        check_zero("rst_mid");
        reset = 1'b1;
        next_cyc();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk($sformatf("rst_mid.no_rd%0d", k), 64'({redirect_valid, busy}), 64'd0);
            next_cyc();
        end
        apply_rows(0, 8);

`ifdef RECOVERY_STATS_EN
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(k <= 8, 32'd365, 5'd10, 1'b1, 1'b0, 1'b1);
            next_cyc();
        end
        @(negedge clock);
        chk("stats.count", 64'(recover_count), 64'd2);
        chk("stats.cycles", 64'(recover_cycles), 64'd14);
        next_cyc();
`endif

        for (int t = 0; t < L; t++) begin
            r_req[t]  = ($urandom_range(0, 3) == 0);
            r_pc[t]   = $urandom;
            r_head[t] = ROB_W'($urandom_range(0, 31));
            r_sqe[t]  = ($urandom_range(0, 3) != 0);
            r_fub[t]  = ($urandom_range(0, 3) == 0);
            r_rdy[t]  = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < 32; j++) r_map[t][j*PR_W +: PR_W] = PR_W'($urandom);
        end
        build_model();
        do_reset();
        for (int t = 0; t < L; t++) begin
            drive(r_req[t], r_pc[t], r_head[t], r_sqe[t], r_fub[t], r_rdy[t]);
            archi_maptable = r_map[t];
            @(negedge clock);
            check_out($sformatf("rnd%0d", t), e_sq[t], e_sq[t], e_hd[t], e_we[t], e_idx[t],
                      e_dat[t], e_rv[t], e_rpc[t], e_busy[t]);
            next_cyc();
        end
`ifdef RECOVERY_STATS_EN
        chk("rnd.count", 64'(recover_count), 64'(n_hs));
        chk("rnd.cycles", 64'(recover_cycles), 64'(n_busy));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
